// File: rtl/sdram_resp_pkg.sv
// Shared types and constants for the SDRAM device-side responder.
package sdram_resp_pkg;

  localparam int unsigned DQ_W      = 32;
  localparam int unsigned DQM_W     = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned BA_W      = 2;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned AP_BIT    = 10;

  localparam int unsigned ERR_W         = 5;
  localparam int unsigned ERR_ACT_OPEN  = 0;
  localparam int unsigned ERR_ACC_IDLE  = 1;
  localparam int unsigned ERR_TRCD      = 2;
  localparam int unsigned ERR_BANK_OPEN = 3;
  localparam int unsigned ERR_MRS       = 4;

  localparam int unsigned MRS_CL_LSB = 4;
  localparam int unsigned MRS_CL_W   = 3;
  localparam int unsigned MRS_BL_LSB = 0;
  localparam int unsigned MRS_BL_W   = 3;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS
  } cmd_e;

  typedef struct packed {
    logic              valid;
    logic [DQ_W-1:0]   data;
    logic [DQM_W-1:0]  mask;
  } rd_beat_t;

  // {ras_n, cas_n, we_n} to command; burst-terminate is treated as NOP
  function automatic cmd_e decode_cmd(input logic [2:0] rcw);
    cmd_e c;
    case (rcw)
      3'b011:  c = CMD_ACT;
      3'b101:  c = CMD_RD;
      3'b100:  c = CMD_WR;
      3'b010:  c = CMD_PRE;
      3'b001:  c = CMD_REF;
      3'b000:  c = CMD_MRS;
      default: c = CMD_NOP;
    endcase
    return c;
  endfunction

  // Only CL 2/3 with single-beat bursts are modelled
  function automatic logic mrs_ok(input logic [ADDR_W-1:0] addr);
    logic [MRS_CL_W-1:0] cl;
    logic [MRS_BL_W-1:0] bl;
    cl = addr[MRS_CL_LSB +: MRS_CL_W];
    bl = addr[MRS_BL_LSB +: MRS_BL_W];
    return ((cl == MRS_CL_W'(2)) || (cl == MRS_CL_W'(3))) && (bl == '0);
  endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// Controller-to-device SDRAM command/address bus (data pad kept separate).
interface sdram_responder_if;
  import sdram_resp_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [BA_W-1:0]   ba;
  logic              cas_n;
  logic              ras_n;
  logic              we_n;
  logic              cs_n;
  logic              cke;
  logic [DQM_W-1:0]  dqm;

  modport master (output addr, ba, cas_n, ras_n, we_n, cs_n, cke, dqm);
  modport slave  (input  addr, ba, cas_n, ras_n, we_n, cs_n, cke, dqm);
endinterface

// File: rtl/sdram_resp_rdpipe.sv
// CAS-latency read pipeline: one beat per READ, lane enables from the sampled DQM.
module sdram_resp_rdpipe
  import sdram_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             push,
  input  logic             cl2,
  input  logic [DQ_W-1:0]  data,
  input  logic [DQM_W-1:0] mask,
  output logic [DQ_W-1:0]  dq_out,
  output logic [DQM_W-1:0] dq_oe
);

  rd_beat_t         s0_q, s0_d, s1_q, s1_d;
  logic [DQ_W-1:0]  out_data_q, out_data_d;
  logic [DQM_W-1:0] out_oe_q, out_oe_d;

  // CL=2 enters one stage later so the beat still lands on T+CL
  always_comb begin
    s0_d       = s0_q;
    s1_d       = s1_q;
    out_data_d = out_data_q;
    out_oe_d   = out_oe_q;
    if (en) begin
      s0_d       = '0;
      s1_d       = s0_q;
      out_data_d = s1_q.data;
      out_oe_d   = s1_q.valid ? ~s1_q.mask : '0;
      if (push) begin
        if (cl2) s1_d = '{valid: 1'b1, data: data, mask: mask};
        else     s0_d = '{valid: 1'b1, data: data, mask: mask};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q       <= '0;
      s1_q       <= '0;
      out_data_q <= '0;
      out_oe_q   <= '0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      out_data_q <= out_data_d;
      out_oe_q   <= out_oe_d;
    end
  end

  assign dq_out = out_data_q;
  assign dq_oe  = out_oe_q;

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device model: command decode, per-bank open-row tracking,
// byte-enabled storage, CAS-latency read return and sticky protocol error flags.
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 8,
  parameter int unsigned TRCD     = 2,
  parameter int unsigned REF_W    = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  sdram_responder_if.slave sdram,
  inout  wire  [DQ_W-1:0]  sdram_dq,
  output logic [ERR_W-1:0] err_flags,
  output logic [REF_W-1:0] refresh_count
);

  localparam int unsigned IDX_W   = BA_W + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH   = 1 << IDX_W;
  localparam int unsigned CNT_W   = (TRCD > 1) ? $clog2(TRCD) : 1;
  localparam int unsigned TRCD_LD = (TRCD > 0) ? TRCD - 1 : 0;

  logic [NUM_BANKS-1:0]               open_q, open_d;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0] row_q, row_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0]    trcd_q, trcd_d;
  logic [ERR_W-1:0]                   err_q, err_d;
  logic [REF_W-1:0]                   ref_cnt_q, ref_cnt_d;
  logic [MRS_CL_W-1:0]                cl_q, cl_d;

  cmd_e             cmd_c;
  logic [IDX_W-1:0] idx_c;
  logic             wr_en_c;
  logic             rd_push_c;
  logic [DQ_W-1:0]  rd_word_c;
  logic [DQ_W-1:0]  rd_dq;
  logic [DQM_W-1:0] rd_oe;
  logic             addr_unused_c;

  logic [DQ_W-1:0]  mem [DEPTH];

  assign cmd_c = (sdram.cke && !sdram.cs_n)
               ? decode_cmd({sdram.ras_n, sdram.cas_n, sdram.we_n}) : CMD_NOP;
  assign idx_c = {sdram.ba, row_q[sdram.ba], sdram.addr[COL_BITS-1:0]};
  assign addr_unused_c = ^sdram.addr;

  // Command decode and bank/mode/error next state
  always_comb begin
    open_d    = open_q;
    row_d     = row_q;
    trcd_d    = trcd_q;
    err_d     = err_q;
    ref_cnt_d = ref_cnt_q;
    cl_d      = cl_q;
    wr_en_c   = 1'b0;
    rd_push_c = 1'b0;
    rd_word_c = '0;

    if (sdram.cke) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (trcd_q[b] != '0) trcd_d[b] = trcd_q[b] - CNT_W'(1);
      end
    end

    unique case (cmd_c)
      CMD_ACT: begin
        if (open_q[sdram.ba]) err_d[ERR_ACT_OPEN] = 1'b1;
        open_d[sdram.ba] = 1'b1;
        row_d[sdram.ba]  = sdram.addr[ROW_BITS-1:0];
        trcd_d[sdram.ba] = CNT_W'(TRCD_LD);
      end
      CMD_RD, CMD_WR: begin
        if (trcd_q[sdram.ba] != '0) err_d[ERR_TRCD] = 1'b1;
        if (!open_q[sdram.ba])         err_d[ERR_ACC_IDLE] = 1'b1;
        else if (sdram.addr[AP_BIT])   open_d[sdram.ba] = 1'b0;
        if (cmd_c == CMD_RD) begin
          rd_push_c = 1'b1;
          if (open_q[sdram.ba]) rd_word_c = mem[idx_c];
        end else begin
          wr_en_c = open_q[sdram.ba];
        end
      end
      CMD_PRE: begin
        if (sdram.addr[AP_BIT]) open_d = '0;
        else                    open_d[sdram.ba] = 1'b0;
      end
      CMD_REF: begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        if (|open_q) err_d[ERR_BANK_OPEN] = 1'b1;
      end
      CMD_MRS: begin
        if (|open_q)                 err_d[ERR_BANK_OPEN] = 1'b1;
        else if (mrs_ok(sdram.addr)) cl_d = sdram.addr[MRS_CL_LSB +: MRS_CL_W];
        else                         err_d[ERR_MRS] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      open_q    <= '0;
      row_q     <= '0;
      trcd_q    <= '0;
      err_q     <= '0;
      ref_cnt_q <= '0;
      cl_q      <= MRS_CL_W'(3);
    end else begin
      open_q    <= open_d;
      row_q     <= row_d;
      trcd_q    <= trcd_d;
      err_q     <= err_d;
      ref_cnt_q <= ref_cnt_d;
      cl_q      <= cl_d;
    end
  end

  // Storage has no reset; contents survive a responder reset
  always_ff @(posedge clk_clk) begin
    if (wr_en_c) begin
      for (int unsigned l = 0; l < DQM_W; l++) begin
        if (!sdram.dqm[l]) mem[idx_c][l*LANE_W +: LANE_W] <= sdram_dq[l*LANE_W +: LANE_W];
      end
    end
  end

  sdram_resp_rdpipe u_rdpipe (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .en     (sdram.cke),
    .push   (rd_push_c),
    .cl2    (cl_q == MRS_CL_W'(2)),
    .data   (rd_word_c),
    .mask   (sdram.dqm),
    .dq_out (rd_dq),
    .dq_oe  (rd_oe)
  );

  for (genvar l = 0; l < DQM_W; l++) begin : g_lane
    assign sdram_dq[l*LANE_W +: LANE_W] = rd_oe[l] ? rd_dq[l*LANE_W +: LANE_W] : {LANE_W{1'bz}};
  end

  assign err_flags     = err_q;
  assign refresh_count = ref_cnt_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: directed command sequences, expected read beats queued by due edge.
module tb_sdram_responder;
  import sdram_resp_pkg::*;

  localparam logic [2:0] R_ACT = 3'b011, R_RD = 3'b101, R_WR = 3'b100,
                         R_PRE = 3'b010, R_REF = 3'b001, R_MRS = 3'b000;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [3:0]  oe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic        tb_drv = 1'b0;
  logic [31:0] tb_dq = '0;
  wire  [31:0] dq_w;
  logic [4:0]  err_flags;
  logic [15:0] refresh_count;

  sdram_responder_if bus();

  assign dq_w = tb_drv ? tb_dq : 32'hzzzz_zzzz;

  sdram_responder #(.ROW_BITS(4), .COL_BITS(8), .TRCD(2), .REF_W(16)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sdram         (bus),
    .sdram_dq      (dq_w),
    .err_flags     (err_flags),
    .refresh_count (refresh_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] oe);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) m[l*8 +: 8] = {8{oe[l]}};
    return m;
  endfunction

  task automatic nop();
    bus.cs_n = 1'b1; bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1;
    bus.ba = '0; bus.addr = '0; bus.dqm = '0;
    tb_drv = 1'b0;
  endtask

  task automatic nops(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [2:0] rcw, input logic [1:0] ba, input logic [10:0] addr,
                       input logic [3:0] dqm, input logic [31:0] wd);
    {bus.ras_n, bus.cas_n, bus.we_n} = rcw;
    bus.cs_n = 1'b0; bus.ba = ba; bus.addr = addr; bus.dqm = dqm;
    tb_drv = (rcw == R_WR); tb_dq = wd;
    @(posedge clk); #1;
    nop();
  endtask

  task automatic wr(input logic [1:0] ba, input logic [7:0] col, input logic [31:0] d, input logic [3:0] dqm);
    issue(R_WR, ba, {3'b000, col}, dqm, d);
  endtask

  // lat = 0 means no beat is expected
  task automatic rd(input logic [1:0] ba, input logic [7:0] col, input logic ap,
                    input logic [3:0] dqm, input logic [31:0] d, input int lat);
    exp_t e;
    if (lat > 0) begin
      e.due = cyc + 1 + lat; e.data = d; e.oe = ~dqm;
      q.push_back(e);
    end
    issue(R_RD, ba, {ap, 2'b00, col}, dqm, 32'h0);
  endtask

  task automatic do_reset();
    nop(); bus.cke = 1'b1; rst_n = 1'b0;
    nops(3);
    rst_n = 1'b1;
    nops(1);
  endtask

  // Monitor: every beat must be queued for exactly this edge
  initial begin
    exp_t        e;
    logic [3:0]  oe_obs;
    forever begin
      @(negedge clk);
      oe_obs = dut.rd_oe;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        e = q.pop_front();
        chk("beat_oe", 32'(oe_obs), 32'(e.oe));
        chk("beat_data", dq_w & lane_mask(e.oe), e.data & lane_mask(e.oe));
      end else if (oe_obs != 4'h0) begin
        chk("stray_beat_oe", 32'(oe_obs), 32'h0);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("reset_err", 32'(err_flags), 32'h0);
    chk("reset_ref", 32'(refresh_count), 32'h0);
    chk("reset_oe", 32'(dut.rd_oe), 32'h0);

    // CL=2 via MRS, write/read, back-to-back and masked reads
    issue(R_MRS, 2'd0, 11'h020, 4'h0, 32'h0);
    chk("mrs_cl2_err", 32'(err_flags), 32'h0);
    issue(R_ACT, 2'd0, 11'd5, 4'h0, 32'h0);
    nops(1);
    wr(2'd0, 8'd3, 32'hDEADBEEF, 4'h0);
    rd(2'd0, 8'd3, 1'b0, 4'h0, 32'hDEADBEEF, 2);
    nops(3);
    wr(2'd0, 8'd4, 32'h12345678, 4'h0);
    rd(2'd0, 8'd3, 1'b0, 4'h0, 32'hDEADBEEF, 2);
    rd(2'd0, 8'd4, 1'b0, 4'h0, 32'h12345678, 2);
    rd(2'd0, 8'd4, 1'b0, 4'b0011, 32'h12345678, 2);
    nops(4);
    chk("cl2_err", 32'(err_flags), 32'h0);

    // Default CL=3 after reset, byte-masked write
    do_reset();
    issue(R_ACT, 2'd0, 11'd5, 4'h0, 32'h0);
    nops(1);
    wr(2'd0, 8'd7, 32'h0, 4'h0);
    wr(2'd0, 8'd7, 32'hDEADBEEF, 4'b0101);
    rd(2'd0, 8'd7, 1'b0, 4'h0, 32'hDE00BE00, 3);
    nops(4);
    chk("cl3_err", 32'(err_flags), 32'h0);

    // tRCD violation still returns data
    issue(R_ACT, 2'd1, 11'd2, 4'h0, 32'h0);
    nops(2);
    wr(2'd1, 8'd0, 32'hCAFEF00D, 4'h0);
    issue(R_PRE, 2'd1, 11'h000, 4'h0, 32'h0);
    issue(R_ACT, 2'd1, 11'd2, 4'h0, 32'h0);
    rd(2'd1, 8'd0, 1'b0, 4'h0, 32'hCAFEF00D, 3);
    nops(4);
    chk("trcd_err", 32'(err_flags), 32'h04);

    // Read of idle bank returns zero; double ACT
    rd(2'd2, 8'd0, 1'b0, 4'h0, 32'h0, 3);
    nops(4);
    chk("idle_rd_err", 32'(err_flags), 32'h06);
    issue(R_PRE, 2'd0, 11'h000, 4'h0, 32'h0);
    issue(R_ACT, 2'd0, 11'd5, 4'h0, 32'h0);
    chk("act_once_err", 32'(err_flags), 32'h06);
    issue(R_ACT, 2'd0, 11'd5, 4'h0, 32'h0);
    chk("act_open_err", 32'(err_flags), 32'h07);

    // REF with open bank, bad MRS, mode retained
    issue(R_REF, 2'd0, 11'h000, 4'h0, 32'h0);
    chk("ref_open_err", 32'(err_flags), 32'h0F);
    chk("ref_count1", 32'(refresh_count), 32'h1);
    issue(R_PRE, 2'd0, 11'h400, 4'h0, 32'h0);
    issue(R_MRS, 2'd0, 11'h050, 4'h0, 32'h0);
    chk("mrs_bad_err", 32'(err_flags), 32'h1F);
    issue(R_ACT, 2'd3, 11'd1, 4'h0, 32'h0);
    nops(2);
    wr(2'd3, 8'd1, 32'hA5A55A5A, 4'h0);
    rd(2'd3, 8'd1, 1'b1, 4'h0, 32'hA5A55A5A, 3);
    rd(2'd3, 8'd1, 1'b0, 4'h0, 32'h0, 3);
    nops(4);

    // Refresh counter wrap
    issue(R_PRE, 2'd0, 11'h400, 4'h0, 32'h0);
    for (int i = 0; i < 65536; i++) issue(R_REF, 2'd0, 11'h000, 4'h0, 32'h0);
    chk("ref_wrap", 32'(refresh_count), 32'h1);
    chk("ref_wrap_err", 32'(err_flags), 32'h1F);

    // CKE low freezes the read pipeline for two edges
    do_reset();
    issue(R_ACT, 2'd0, 11'd5, 4'h0, 32'h0);
    nops(2);
    rd(2'd0, 8'd3, 1'b0, 4'h0, 32'hDEADBEEF, 5);
    bus.cke = 1'b0;
    nops(2);
    bus.cke = 1'b1;
    nops(6);

    // Reset during the beat drops it and releases dq at once
    rd(2'd0, 8'd3, 1'b0, 4'h0, 32'h0, 0);
    nops(2);
    chk("beat_pre_reset_oe", 32'(dut.rd_oe), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("reset_release_oe", 32'(dut.rd_oe), 32'h0);
    nops(3);
    rst_n = 1'b1;
    nops(6);
    chk("post_reset_err", 32'(err_flags), 32'h0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
